// File: rtl/hazard_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_unit_if
//
// Purpose: groups the decode-stage request and the hazard answer that passes
// between the pipeline's decode logic and the hazard unit.
//
// Parameters:
//   SEL_W        forward-select width; must match the hazard unit's SEL_W.
//
// Signals:
//   Instr        decode-stage MIPS instruction (32'hffffffff is a bubble)
//   Instr_valid  Instr is a real instruction; 0 means treat it as a bubble
//   Flush        decode-stage instruction is being killed (taken branch)
//   Fwd_a        source for rs: 0 = register file, k = result at distance k
//   Fwd_b        source for rt, same encoding as Fwd_a
//   Stall        hold PC and decode, inject a bubble into E
//
// Modports:
//   master       decode side: drives the instruction, receives the answer
//   slave        hazard unit: receives the instruction, drives the answer
// -----------------------------------------------------------------------------
interface hazard_unit_if #(
  parameter int SEL_W = 3
);

  logic [31:0]      Instr;
  logic             Instr_valid;
  logic             Flush;
  logic [SEL_W-1:0] Fwd_a;
  logic [SEL_W-1:0] Fwd_b;
  logic             Stall;

  modport master (
    output Instr,
    output Instr_valid,
    output Flush,
    input  Fwd_a,
    input  Fwd_b,
    input  Stall
  );

  modport slave (
    input  Instr,
    input  Instr_valid,
    input  Flush,
    output Fwd_a,
    output Fwd_b,
    output Stall
  );

endinterface

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Purpose: data-hazard detection for a classic in-order MIPS pipeline. A
// DEPTH-entry shadow shift register mirrors what each stage after decode will
// write (entry 1 = E, 2 = M, 3 = W, ...). The decode-stage instruction is
// compared against it to pick forwarding sources for rs/rt and to detect the
// one load-use case that forwarding cannot cover, which raises Stall.
//
// Parameters:
//   DEPTH        producer stages tracked after decode (2..7)
//   REG_W        register address width
//   SEL_W        forward-select width, 2**SEL_W > DEPTH
//
// Ports:
//   Clk          clock, rising edge
//   Rst_n        asynchronous active-low reset
//   bus          hazard_unit_if.slave: Instr, Instr_valid, Flush in;
//                Fwd_a, Fwd_b, Stall out (combinational, zero latency)
//   Stall_cnt    (only with HAZARD_STATS_EN) saturating count of stall cycles
//
// Build option:
//   HAZARD_STATS_EN  when defined, adds the Stall_cnt output and its counter.
//                    When undefined the port and counter do not exist.
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int DEPTH = 3,
  parameter int REG_W = 5,
  parameter int SEL_W = 3
) (
  input  logic        Clk,
  input  logic        Rst_n,
  hazard_unit_if.slave bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] Stall_cnt
`endif
);

  // MIPS primary opcodes the unit understands.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [31:0] BUBBLE_WORD = 32'hffff_ffff;

  // One shadow entry: what the instruction in that stage will write back.
  typedef struct packed {
    logic             wr_en;
    logic [REG_W-1:0] dest;
    logic             is_load;
  } entry_t;

  // Entry k is the instruction k stages past decode.
  entry_t [DEPTH:1] shadow;

  // ---------------------------------------------------------------------------
  // Decode of the decode-stage instruction
  // ---------------------------------------------------------------------------
  logic [5:0]       opcode;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic [REG_W-1:0] rd;
  logic             is_bubble;
  logic             reads_rs;
  logic             reads_rt;
  entry_t           dec;

  assign opcode    = bus.Instr[31:26];
  assign rs        = REG_W'(bus.Instr[25:21]);
  assign rt        = REG_W'(bus.Instr[20:16]);
  assign rd        = REG_W'(bus.Instr[15:11]);
  assign is_bubble = !bus.Instr_valid || (bus.Instr == BUBBLE_WORD);

  // shamt/funct/low immediate bits never influence hazards.
  logic unused_low_bits;
  assign unused_low_bits = ^bus.Instr[10:0];

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    dec      = '0;
    if (!is_bubble) begin
      case (opcode)
        OP_RTYPE: begin
          reads_rs  = 1'b1;
          reads_rt  = 1'b1;
          dec.wr_en = 1'b1;
          dec.dest  = rd;
        end
        OP_LW: begin
          reads_rs    = 1'b1;
          dec.wr_en   = 1'b1;
          dec.dest    = rt;
          dec.is_load = 1'b1;
        end
        OP_SW, OP_BEQ: begin
          reads_rs = 1'b1;
          reads_rt = 1'b1;
        end
        OP_ADDI, OP_ORI: begin
          reads_rs  = 1'b1;
          dec.wr_en = 1'b1;
          dec.dest  = rt;
        end
        default: ;  // unknown opcode: no reads, no writes
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard resolution (combinational from shadow + Instr)
  // ---------------------------------------------------------------------------
  logic             load_use;
  logic             stall;
  logic [SEL_W-1:0] fwd_a;
  logic [SEL_W-1:0] fwd_b;

  always_comb begin
    // A load one stage ahead has no result yet; only a stall can cover it.
    // Register 0 is hard-wired and never creates a dependency.
    load_use = shadow[1].is_load && shadow[1].wr_en && (shadow[1].dest != '0) &&
               ((reads_rs && (shadow[1].dest == rs)) ||
                (reads_rt && (shadow[1].dest == rt)));
    // A flushed instruction never executes, so it must not stall the pipe.
    stall = load_use && !bus.Flush;

    // Scan farthest to nearest so the nearest writer overwrites older ones.
    fwd_a = '0;
    fwd_b = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (reads_rs && shadow[k].wr_en && (shadow[k].dest != '0) &&
          (shadow[k].dest == rs)) begin
        fwd_a = SEL_W'(k);
      end
      if (reads_rt && shadow[k].wr_en && (shadow[k].dest != '0) &&
          (shadow[k].dest == rt)) begin
        fwd_b = SEL_W'(k);
      end
    end

    // The instruction is replayed next cycle; selects are meaningless now.
    if (stall) begin
      fwd_a = '0;
      fwd_b = '0;
    end
  end

  assign bus.Fwd_a = fwd_a;
  assign bus.Fwd_b = fwd_b;
  assign bus.Stall = stall;

  // ---------------------------------------------------------------------------
  // Shadow shift register
  // ---------------------------------------------------------------------------
  entry_t entry1_next;

  // A stalled or flushed decode slot enters E as a bubble. Bubbles and invalid
  // slots already decode to all-zero.
  assign entry1_next = (stall || bus.Flush) ? '0 : dec;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      // NOTE: the shadow register is real pipeline state rather than a data
      // buffer; stale entries after reset would raise false hazards, so every
      // entry is cleared.
      shadow <= '0;
    end else begin
      // NOTE: non-blocking assignment so every entry shifts from its value
      // before the edge, independent of statement order.
      shadow <= {shadow[DEPTH-1:1], entry1_next};
    end
  end

`ifdef HAZARD_STATS_EN
  // ---------------------------------------------------------------------------
  // Stall statistics: saturating count of stall cycles
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Stall_cnt <= '0;
    end else if (stall && (Stall_cnt != 16'hffff)) begin
      Stall_cnt <= Stall_cnt + 16'd1;
    end
  end
`endif

endmodule
